elevator_sched: RTL and testbench
=================================

# elevator_sched

Scheduling controller for an 8-floor elevator car. Latches floor-call buttons and runs a collective (SCAN) policy: keep travelling in the current direction while calls remain ahead, otherwise reverse, otherwise idle. Produces the registered `floornum` / `state` pair that feeds the seven-segment floor/direction decoder, plus a door-open indication.

## Interface
Parameters:
- `TRAVEL_CYCLES`, 16, clock cycles to travel one floor; legal range ≥ 1.
- `DOOR_CYCLES`, 8, clock cycles the door stays open; legal range ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 8: floor-call buttons, one bit per floor; level or pulse; sampled every cycle.
- `floornum` out 3: current floor, registered.
- `state` out 2: motion code, registered. 00 idle, 01 up, 10 down, 11 door open.
- `door_open` out 1: high exactly while `state` = 11.
- `pending` out 8: latched outstanding calls.
- `door_hold` in 1: present only with `ELEV_DOOR_HOLD_EN`.

## Operation
- Reset values: `floornum`=0, `state`=00, `door_open`=0, `pending`=0, internal direction `dir`=up, timer=0.
- Call capture: each cycle, `pending <= pending | req`, except bits cleared by service in the same cycle. Clear wins over set for the serviced floor.
- "Effective calls" for every decision = `pending | req` of the current cycle.
- Floors above current floor are the `above` set; floors below are the `below` set. Each set is empty at the top or bottom floor, so there is no wrap-around.
- IDLE:
  - Call at current floor → DOOR.
  - Else any call above → UP.
  - Else any call below → DOWN.
  - Up is preferred on a tie.
- UP / DOWN:
  - Timer loads `TRAVEL_CYCLES-1` on entry and counts down.
  - At 0, `floornum` increments or decrements.
  - If the new floor has an effective call: clear it and go to DOOR.
  - Else reload the timer and continue.
  - Movement is entered only when a call lies ahead. Calls are never withdrawn, so the car cannot overrun floor 0 or floor 7.
- DOOR:
  - Timer loads `DOOR_CYCLES-1` on entry and the current-floor bit is cleared.
  - A call for the current floor during DOOR reloads the timer and is not latched.
  - At timer 0: if `dir`=up and calls above → UP; else calls below → DOWN; else calls above → UP; else IDLE.
- `dir` updates on every entry to UP or DOWN.
- Reset asserted mid-travel or mid-door: immediate return to reset values. Car position is lost, and floor 0 is reported.

## Timing
- Every output is a flop; no combinational input-to-output path.
- Call at the current floor while IDLE, sampled at edge t: `state`=11 after edge t+1.
- Call at floor k>f while IDLE at f, sampled at edge t:
  - `state`=01 at t+1.
  - `floornum`=f+n at t+1+n·`TRAVEL_CYCLES`.
  - `state`=11 at the same edge the car reaches k.
- Door interval is `DOOR_CYCLES` cycles with `door_open`=1. The next state appears on the following edge.
- A call arriving on the exact cycle the car arrives at that floor is serviced, not latched.
- Timer width: `$clog2(max(TRAVEL_CYCLES,DOOR_CYCLES))`, minimum 1 bit.

## Configuration
- `ELEV_DOOR_HOLD_EN` defined: adds the `door_hold` input. While `door_hold`=1 in DOOR, the timer reloads `DOOR_CYCLES-1` every cycle. After release, the door closes `DOOR_CYCLES` cycles later.
- `ELEV_DOOR_HOLD_EN` undefined: no `door_hold` port, and the door time is fixed.

## Structure
- Package `elev_pkg` holds:
  - `NUM_FLOORS`=8 and `FLOOR_W`=3.
  - The `state` code enum: `ST_IDLE`, `ST_UP`, `ST_DOWN`, `ST_DOOR`.
  - The direction typedef.
- The encodings 01/10 are fixed by the existing display decoder and must not change.
- Sub-module `elev_timer`: loadable down-counter with `load`, `load_val`, and a `zero` flag. It is shared between travel and door timing.
- Above/below masks are combinational functions in the package.

## Test plan
- Reset mid-move:
  - Stimulus: call floor 5, then deassert `rst_n` at cycle 20 while moving.
  - Required: all outputs return to reset values asynchronously; `pending`=0.
- Local call:
  - Stimulus: idle at floor 0, `req`=8'h01 for one cycle at t.
  - Required: `state`=11 at t+1; `door_open` high for 8 cycles; then `state`=00 and `pending`=0.
- Single trip up:
  - Stimulus: `req[3]` pulse at t from floor 0.
  - Required: `state`=01 at t+1; `floornum` 1/2/3 at t+17/t+33/t+49; `state`=11 at t+49.
- SCAN ordering:
  - Stimulus: at floor 3 moving up, calls 6 and 1 pending.
  - Required: serves 6 first, then reverses; `state`=10; then serves 1.
- Simultaneous arrival and call:
  - Stimulus: `req[2]` asserted on the exact cycle the car reaches floor 2 with no prior call there.
  - Required: the car stops at 2 and bit 2 is never set in `pending`.
- Door hold (with `ELEV_DOOR_HOLD_EN`):
  - Stimulus: `door_hold` held for 20 cycles during DOOR.
  - Required: `door_open` stays 1 for the full 20 cycles plus 8 cycles after release.

Source files
------------

// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - shared constants, state/direction types and floor mask helpers for elevator_sched
package elev_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;

    // The 01/10 codes are decoded directly by the floor/direction display.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DOOR = 2'b11
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Floors strictly above f; empty at the top floor.
    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i > int'(f));
        end
        return m;
    endfunction

    // Floors strictly below f; empty at floor 0.
    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i < int'(f));
        end
        return m;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// rtl/elev_timer.sv - loadable down-counter shared by travel and door timing
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load, load_val    load the counter (takes priority over counting)
//   zero              counter has reached 0; it holds at 0 until reloaded
module elev_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/elevator_sched.sv
// rtl/elevator_sched.sv - SCAN scheduling controller for an 8-floor elevator car
//
// Parameters:
//   TRAVEL_CYCLES  cycles to travel one floor (>= 1)
//   DOOR_CYCLES    cycles the door stays open (>= 1)
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req            floor-call buttons, one bit per floor, sampled every cycle
//   floornum       current floor (registered)
//   state          00 idle, 01 up, 10 down, 11 door open (registered)
//   door_open      high exactly while state = 11 (registered)
//   pending        latched outstanding calls (registered)
//   door_hold      only with ELEV_DOOR_HOLD_EN: keeps the door open while high
module elevator_sched
    import elev_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floornum,
    output logic [1:0]            state,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
`ifdef ELEV_DOOR_HOLD_EN
    ,
    input  logic                  door_hold
`endif
);

    localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);

    state_t                  st_q, st_nx;
    dir_t                    dir_q, dir_nx;
    logic [FLOOR_W-1:0]      floor_q, floor_nx, step_floor;
    logic [NUM_FLOORS-1:0]   pend_q, pend_nx, eff, clr, above, below;
    logic                    door_q;
    logic                    tmr_load, tmr_zero;
    logic [TMR_W-1:0]        tmr_val;
    logic                    hold;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    elev_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        // A call arriving this cycle counts for every decision, so a car
        // reaching that floor services it instead of latching it.
        eff        = pend_q | req;
        above      = eff & above_mask(floor_q);
        below      = eff & below_mask(floor_q);
        st_nx      = st_q;
        dir_nx     = dir_q;
        floor_nx   = floor_q;
        clr        = '0;
        tmr_load   = 1'b0;
        tmr_val    = TRAVEL_LOAD;
        step_floor = (st_q == ST_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);

        unique case (st_q)
            ST_IDLE: begin
                if (eff[floor_q]) begin
                    st_nx        = ST_DOOR;
                    clr[floor_q] = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = DOOR_LOAD;
                end else if (|above) begin
                    st_nx    = ST_UP;
                    dir_nx   = DIR_UP;
                    tmr_load = 1'b1;
                end else if (|below) begin
                    st_nx    = ST_DOWN;
                    dir_nx   = DIR_DOWN;
                    tmr_load = 1'b1;
                end
            end
            ST_UP, ST_DOWN: begin
                if (tmr_zero) begin
                    floor_nx = step_floor;
                    tmr_load = 1'b1;
                    if (eff[step_floor]) begin
                        st_nx           = ST_DOOR;
                        clr[step_floor] = 1'b1;
                        tmr_val         = DOOR_LOAD;
                    end
                end
            end
            ST_DOOR: begin
                // Calls for the open floor are absorbed and keep the door open.
                clr[floor_q] = 1'b1;
                if (req[floor_q] || hold) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (tmr_zero) begin
                    if (dir_q == DIR_UP && |above) begin
                        st_nx    = ST_UP;
                        dir_nx   = DIR_UP;
                        tmr_load = 1'b1;
                    end else if (|below) begin
                        st_nx    = ST_DOWN;
                        dir_nx   = DIR_DOWN;
                        tmr_load = 1'b1;
                    end else if (|above) begin
                        st_nx    = ST_UP;
                        dir_nx   = DIR_UP;
                        tmr_load = 1'b1;
                    end else begin
                        st_nx = ST_IDLE;
                    end
                end
            end
            default: st_nx = ST_IDLE;
        endcase

        pend_nx = eff & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            dir_q   <= DIR_UP;
            floor_q <= '0;
            pend_q  <= '0;
            door_q  <= 1'b0;
        end else begin
            st_q    <= st_nx;
            dir_q   <= dir_nx;
            floor_q <= floor_nx;
            pend_q  <= pend_nx;
            door_q  <= (st_nx == ST_DOOR);
        end
    end

    assign floornum  = floor_q;
    assign state     = st_q;
    assign door_open = door_q;
    assign pending   = pend_q;

endmodule

// File: tb/tb_elevator_sched.sv
// tb/tb_elevator_sched.sv - self-checking bench for elevator_sched
module tb_elevator_sched;

    localparam int T = 16;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] floornum;
    logic [1:0] state;
    logic       door_open;
    logic [7:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
    logic       door_hold;
`endif

    elevator_sched #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .floornum  (floornum),
        .state     (state),
        .door_open (door_open),
        .pending   (pending)
`ifdef ELEV_DOOR_HOLD_EN
        ,
        .door_hold (door_hold)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: position, activity (0 idle,1 up,2 down,3 door),
    // cycles spent in the current leg, heading, and outstanding calls.
    int       m_floor;
    int       m_mode;
    int       m_elapsed;
    bit       m_dir_up;
    bit [7:0] m_calls;

    function automatic void model_reset();
        m_floor   = 0;
        m_mode    = 0;
        m_elapsed = 0;
        m_dir_up  = 1'b1;
        m_calls   = '0;
    endfunction

    function automatic void model_step(input bit [7:0] r, input bit h);
        bit [7:0] eff;
        bit       a, b;
        eff = m_calls | r;
        a = 0;
        b = 0;
        for (int i = 0; i < 8; i++) begin
            if (eff[i] && i > m_floor) a = 1;
            if (eff[i] && i < m_floor) b = 1;
        end
        m_calls = eff;
        case (m_mode)
            0: begin
                if (eff[m_floor]) begin
                    m_mode = 3; m_elapsed = 0; m_calls[m_floor] = 0;
                end else if (a) begin
                    m_mode = 1; m_elapsed = 0; m_dir_up = 1;
                end else if (b) begin
                    m_mode = 2; m_elapsed = 0; m_dir_up = 0;
                end
            end
            1, 2: begin
                m_elapsed++;
                if (m_elapsed == T) begin
                    m_floor   = (m_mode == 1) ? m_floor + 1 : m_floor - 1;
                    m_elapsed = 0;
                    if (eff[m_floor]) begin
                        m_mode = 3; m_calls[m_floor] = 0;
                    end
                end
            end
            default: begin
                m_calls[m_floor] = 0;
                if (r[m_floor] || h) begin
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == D) begin
                        m_elapsed = 0;
                        if (m_dir_up && a)  begin m_mode = 1; m_dir_up = 1; end
                        else if (b)         begin m_mode = 2; m_dir_up = 0; end
                        else if (a)         begin m_mode = 1; m_dir_up = 1; end
                        else                m_mode = 0;
                    end
                end
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] ef, es;
        ef = 8'(m_floor);
        es = 8'(m_mode);
        chk({tag, " floornum"},  {5'b0, floornum},  ef);
        chk({tag, " state"},     {6'b0, state},     es);
        chk({tag, " door_open"}, {7'b0, door_open}, {7'b0, m_mode == 3});
        chk({tag, " pending"},   pending,           m_calls);
    endtask

    // Drive one cycle of inputs starting at a falling edge; return at the next falling edge.
    task automatic tick(input logic [7:0] r, input bit h);
        req = r;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold = h;
`endif
        model_step(r, h);
        @(posedge clk);
        @(negedge clk);
        req = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] req;
        int         n;
        logic [2:0] fl;
        logic [1:0] st;
        logic       dr;
        logic [7:0] pend;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        bit         h;

        // Each row: apply req for one cycle, idle for n-1 more, then expect these outputs.
        // Local call at floor 0.
        tbl.push_back('{8'h01, 1,  3'd0, 2'b11, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 7,  3'd0, 2'b11, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 1,  3'd0, 2'b00, 1'b0, 8'h00});
        // Single trip 0 -> 3.
        tbl.push_back('{8'h08, 1,  3'd0, 2'b01, 1'b0, 8'h08});
        tbl.push_back('{8'h00, 15, 3'd0, 2'b01, 1'b0, 8'h08});
        tbl.push_back('{8'h00, 1,  3'd1, 2'b01, 1'b0, 8'h08});
        tbl.push_back('{8'h00, 16, 3'd2, 2'b01, 1'b0, 8'h08});
        tbl.push_back('{8'h00, 15, 3'd2, 2'b01, 1'b0, 8'h08});
        tbl.push_back('{8'h00, 1,  3'd3, 2'b11, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 8,  3'd3, 2'b00, 0, 8'h00});
        // SCAN from floor 3 with calls 6 and 1.
        tbl.push_back('{8'h42, 1,  3'd3, 2'b01, 1'b0, 8'h42});
        tbl.push_back('{8'h00, 48, 3'd6, 2'b11, 1'b1, 8'h02});
        tbl.push_back('{8'h00, 8,  3'd6, 2'b10, 1'b0, 8'h02});
        tbl.push_back('{8'h00, 80, 3'd1, 2'b11, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 8,  3'd1, 2'b00, 1'b0, 8'h00});
        // Floor 1 -> 4, with a call for 2 arriving on the arrival cycle.
        tbl.push_back('{8'h10, 1,  3'd1, 2'b01, 1'b0, 8'h10});
        tbl.push_back('{8'h00, 15, 3'd1, 2'b01, 1'b0, 8'h10});
        tbl.push_back('{8'h04, 1,  3'd2, 2'b11, 1'b1, 8'h10});
        tbl.push_back('{8'h00, 8,  3'd2, 2'b01, 1'b0, 8'h10});
        tbl.push_back('{8'h00, 32, 3'd4, 2'b11, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 8,  3'd4, 2'b00, 1'b0, 8'h00});

        // Reset values while reset is held.
        rst_n = 1'b0;
        req   = '0;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        #1;
        chk("reset floornum",  {5'b0, floornum},  8'h00);
        chk("reset state",     {6'b0, state},     8'h00);
        chk("reset door_open", {7'b0, door_open}, 8'h00);
        chk("reset pending",   pending,           8'h00);
        @(negedge clk);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].req, 1'b0);
            for (int k = 1; k < tbl[i].n; k++) tick(8'h00, 1'b0);
            chk($sformatf("row%0d floornum", i),  {5'b0, floornum},  {5'b0, tbl[i].fl});
            chk($sformatf("row%0d state", i),     {6'b0, state},     {6'b0, tbl[i].st});
            chk($sformatf("row%0d door_open", i), {7'b0, door_open}, {7'b0, tbl[i].dr});
            chk($sformatf("row%0d pending", i),   pending,           tbl[i].pend);
        end

        // Reset mid-move: call floor 5, asynchronous reset at cycle 20.
        do_reset();
        tick(8'h20, 1'b0);
        for (int k = 1; k < 20; k++) tick(8'h00, 1'b0);
        chk("premove state",    {6'b0, state},    8'h01);
        chk("premove floornum", {5'b0, floornum}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async floornum",  {5'b0, floornum},  8'h00);
        chk("async state",     {6'b0, state},     8'h00);
        chk("async door_open", {7'b0, door_open}, 8'h00);
        chk("async pending",   pending,           8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(8'h00, 1'b0);
        chk_model("post reset");

`ifdef ELEV_DOOR_HOLD_EN
        // Door held for 20 cycles, then closes DOOR_CYCLES cycles after release.
        do_reset();
        tick(8'h01, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick(8'h00, 1'b1);
            chk($sformatf("hold%0d door_open", k), {7'b0, door_open}, 8'h01);
        end
        for (int k = 0; k < D - 1; k++) begin
            tick(8'h00, 1'b0);
            chk($sformatf("release%0d door_open", k), {7'b0, door_open}, 8'h01);
        end
        tick(8'h00, 1'b0);
        chk("closed door_open", {7'b0, door_open}, 8'h00);
        chk_model("after hold");
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = '0;
            if ($urandom_range(0, 11) == 0) r[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 199) == 0) r = 8'($urandom);
            h = 1'b0;
`ifdef ELEV_DOOR_HOLD_EN
            h = ($urandom_range(0, 15) == 0);
`endif
            tick(r, h);
            chk_model($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
